// File: rtl/mem_io_responder_if.sv
// Byte-serial bus between the CPU memory controller (master) and the memory-side responder (slave).
interface mem_io_responder_if;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;

    modport master (
        output rdy, mem_a, mem_wr, mem_wdata,
        input  mem_rdata, io_buffer_full
    );

    modport slave (
        input  rdy, mem_a, mem_wr, mem_wdata,
        output mem_rdata, io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM plus memory-mapped UART TX/RX FIFOs and a halt register.
// Reads answer with one-cycle latency; TX almost-full drives controller back-pressure.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_io_responder_if.slave    bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 sim_halt,
    output logic [7:0]           halt_code,
    output logic                 tx_overflow
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [17:0]      IO_DATA  = 18'h30000;
    localparam logic [17:0]      IO_STAT  = 18'h30004;
    localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(FIFO_DEPTH - 2);
    localparam logic [PTR_W-1:0] ZERO_P   = '0;

    logic [7:0]       ram_r [0:(2**ADDR_WIDTH)-1];
    logic [7:0]       tx_mem_r [0:FIFO_DEPTH-1];
    logic [7:0]       rx_mem_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
    logic [7:0]       mem_rdata_r, tx_data_r, halt_code_r;
    logic             io_full_r, tx_valid_r, sim_halt_r, tx_overflow_r;

    logic                  io_sel_s, ram_wr_s, rd_s, halt_wr_s;
    logic [17:0]           io_off_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [PTR_W-1:0]      tx_count_s, rx_count_s, tx_count_nxt_s, tx_rd_nxt_s;
    logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic                  tx_wr_req_s, tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic [7:0]            rdata_nxt_s, tx_data_nxt_s;
    logic                  unused_addr_s;

    assign io_sel_s      = (bus.mem_a[17:16] == 2'b11);
    assign io_off_s      = bus.mem_a[17:0];
    assign ram_addr_s    = bus.mem_a[ADDR_WIDTH-1:0];
    assign unused_addr_s = ^bus.mem_a[31:18];

    assign tx_count_s = tx_wr_ptr_r - tx_rd_ptr_r;
    assign rx_count_s = rx_wr_ptr_r - rx_rd_ptr_r;
    assign tx_full_s  = (tx_count_s == DEPTH_P);
    assign tx_empty_s = (tx_count_s == ZERO_P);
    assign rx_full_s  = (rx_count_s == DEPTH_P);
    assign rx_empty_s = (rx_count_s == ZERO_P);

    // Bus decode; reset discards any access in flight.
    assign rd_s        = bus.rdy && !bus.mem_wr;
    assign ram_wr_s    = !rst && bus.rdy && bus.mem_wr && !io_sel_s;
    assign tx_wr_req_s = bus.rdy && bus.mem_wr && io_sel_s && (io_off_s == IO_DATA);
    assign halt_wr_s   = bus.rdy && bus.mem_wr && io_sel_s && (io_off_s == IO_STAT);
    assign tx_push_s   = !rst && tx_wr_req_s && !tx_full_s;
    assign tx_pop_s    = !tx_empty_s && tx_ready;
    assign rx_push_s   = !rst && rx_valid && !rx_full_s;
    assign rx_pop_s    = rd_s && io_sel_s && (io_off_s == IO_DATA) && !rx_empty_s;

    assign tx_count_nxt_s = tx_count_s + PTR_W'(tx_push_s) - PTR_W'(tx_pop_s);
    assign tx_rd_nxt_s    = tx_rd_ptr_r + PTR_W'(tx_pop_s);

    // Read-data mux: IO registers sample FIFO state before this edge's pushes/pops.
    always_comb begin
        rdata_nxt_s = 8'h00;
        if (io_sel_s) begin
            case (io_off_s)
                IO_DATA: rdata_nxt_s = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r[IDX_W-1:0]];
                IO_STAT: rdata_nxt_s = {6'b000000, !rx_empty_s, tx_full_s};
                default: rdata_nxt_s = 8'h00;
            endcase
        end else begin
            rdata_nxt_s = ram_r[ram_addr_s];
        end
    end

    // Next TX head: a byte pushed this edge becomes the head when it lands at the new read pointer.
    always_comb begin
        tx_data_nxt_s = 8'h00;
        if (tx_count_nxt_s == ZERO_P) begin
            tx_data_nxt_s = 8'h00;
        end else if (tx_push_s && (tx_wr_ptr_r == tx_rd_nxt_s)) begin
            tx_data_nxt_s = bus.mem_wdata;
        end else begin
            tx_data_nxt_s = tx_mem_r[tx_rd_nxt_s[IDX_W-1:0]];
        end
    end

    // RAM storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_wr_s) ram_r[ram_addr_s] <= bus.mem_wdata;
    end

    // FIFO storage arrays.
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r[IDX_W-1:0]] <= bus.mem_wdata;
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r[IDX_W-1:0]] <= rx_data;
    end

    // Pointers, read data, back-pressure, TX head and halt/overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_r   <= '0;
            tx_rd_ptr_r   <= '0;
            rx_wr_ptr_r   <= '0;
            rx_rd_ptr_r   <= '0;
            mem_rdata_r   <= 8'h00;
            io_full_r     <= 1'b0;
            tx_valid_r    <= 1'b0;
            tx_data_r     <= 8'h00;
            sim_halt_r    <= 1'b0;
            halt_code_r   <= 8'h00;
            tx_overflow_r <= 1'b0;
        end else begin
            tx_wr_ptr_r <= tx_wr_ptr_r + PTR_W'(tx_push_s);
            tx_rd_ptr_r <= tx_rd_nxt_s;
            rx_wr_ptr_r <= rx_wr_ptr_r + PTR_W'(rx_push_s);
            rx_rd_ptr_r <= rx_rd_ptr_r + PTR_W'(rx_pop_s);
            if (rd_s) mem_rdata_r <= rdata_nxt_s;
            io_full_r  <= (tx_count_nxt_s >= AF_LEVEL);
            tx_valid_r <= (tx_count_nxt_s != ZERO_P);
            tx_data_r  <= tx_data_nxt_s;
            sim_halt_r <= halt_wr_s;
            if (halt_wr_s) halt_code_r <= bus.mem_wdata;
            if (tx_wr_req_s && tx_full_s) tx_overflow_r <= 1'b1;
        end
    end

    assign bus.mem_rdata      = mem_rdata_r;
    assign bus.io_buffer_full = io_full_r;
    assign tx_data            = tx_data_r;
    assign tx_valid           = tx_valid_r;
    assign sim_halt           = sim_halt_r;
    assign halt_code          = halt_code_r;
    assign tx_overflow        = tx_overflow_r;
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: read data goes through an expected-value queue.
module tb_mem_io_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sim_halt;
    logic [7:0] halt_code;
    logic       tx_overflow;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    mem_io_responder_if bus();

    mem_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .sim_halt(sim_halt), .halt_code(halt_code), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        bus.rdy = 1'b1; bus.mem_wr = 1'b1; bus.mem_a = a; bus.mem_wdata = d;
        tick();
        bus.rdy = 1'b0; bus.mem_wr = 1'b0; bus.mem_a = 32'h0; bus.mem_wdata = 8'h00;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [7:0] e, input string tag);
        logic [7:0] exp_v;
        string      tag_v;
        bus.rdy = 1'b1; bus.mem_wr = 1'b0; bus.mem_a = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        bus.rdy = 1'b0; bus.mem_a = 32'h0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            check(tag_v, {24'h0, bus.mem_rdata}, {24'h0, exp_v});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        bus.rdy = 1'b0; bus.mem_wr = 1'b0; bus.mem_a = 32'h0; bus.mem_wdata = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_mem_rdata", {24'h0, bus.mem_rdata}, 32'h0);
        check("rst_io_full", {31'h0, bus.io_buffer_full}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_sim_halt", {31'h0, sim_halt}, 32'h0);
        check("rst_halt_code", {24'h0, halt_code}, 32'h0);
        check("rst_tx_overflow", {31'h0, tx_overflow}, 32'h0);

        // RAM round trip, truncation/aliasing and unmapped IO
        bus_write(32'h0000_0100, 8'h11);
        bus_write(32'h0000_0101, 8'h22);
        bus_write(32'h0000_0102, 8'h33);
        bus_write(32'h0000_0103, 8'h44);
        bus_read(32'h0000_0100, 8'h11, "ram_rd_100");
        bus_read(32'h0000_0101, 8'h22, "ram_rd_101");
        bus_read(32'h0000_0102, 8'h33, "ram_rd_102");
        bus_read(32'h0000_0103, 8'h44, "ram_rd_103");
        bus_write(32'h0000_0010, 8'hAB);
        bus_write(32'h0000_0005, 8'h5C);
        bus_write(32'h0001_FFFF, 8'hE7);
        bus_read(32'hFFFC_0005, 8'h5C, "ram_alias_hi_bits");
        bus_read(32'h0001_FFFF, 8'hE7, "ram_top_byte");
        bus_read(32'h0003_0008, 8'h00, "io_unmapped_rd");
        bus_read(32'h0000_0010, 8'hAB, "ram_rd_010");

        // TX back-pressure and overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus_write(32'h0003_0000, 8'h41);
            if (i == 5) check("io_full_after_5", {31'h0, bus.io_buffer_full}, 32'h0);
            if (i == 6) check("io_full_after_6", {31'h0, bus.io_buffer_full}, 32'h1);
            if (i == 8) check("ovf_after_8", {31'h0, tx_overflow}, 32'h0);
            if (i == 9) check("ovf_after_9", {31'h0, tx_overflow}, 32'h1);
        end
        bus_read(32'h0003_0004, 8'h01, "status_tx_full");
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", {31'h0, tx_valid}, 32'h1);
            check("drain_data", {24'h0, tx_data}, 32'h41);
            tick();
        end
        check("drained_valid", {31'h0, tx_valid}, 32'h0);
        check("drained_io_full", {31'h0, bus.io_buffer_full}, 32'h0);

        // TX ordering, with a push and pop on the same edge
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) bus_write(32'h0003_0000, 8'hA0 + 8'(i));
        check("tx_head_a1", {24'h0, tx_data}, 32'hA1);
        tx_ready = 1'b1;
        bus_write(32'h0003_0000, 8'hA5);
        for (int k = 0; k < 4; k++) begin
            check("tx_order", {24'h0, tx_data}, {24'h0, 8'hA2 + 8'(k)});
            tick();
        end
        check("tx_order_empty", {31'h0, tx_valid}, 32'h0);

        // RX read
        rx_data = 8'h5A; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        bus_read(32'h0003_0004, 8'h02, "status_rx_nonempty");
        bus_read(32'h0003_0000, 8'h5A, "rx_pop_5a");
        bus_read(32'h0003_0000, 8'h00, "rx_empty_rd");
        bus_read(32'h0003_0004, 8'h00, "status_idle");

        // RX full: ninth byte dropped
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h60 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        bus_read(32'h0003_0004, 8'h02, "status_rx_full");
        for (int i = 0; i < 8; i++) bus_read(32'h0003_0000, 8'h60 + 8'(i), "rx_fifo_order");
        bus_read(32'h0003_0000, 8'h00, "rx_drop_on_full");

        // RX push and pop on empty: no bypass
        rx_data = 8'h77; rx_valid = 1'b1;
        bus_read(32'h0003_0000, 8'h00, "rx_no_bypass");
        rx_valid = 1'b0;
        bus_read(32'h0003_0000, 8'h77, "rx_after_bypass");

        // Halt
        bus_write(32'h0003_0004, 8'h07);
        check("halt_pulse", {31'h0, sim_halt}, 32'h1);
        check("halt_code", {24'h0, halt_code}, 32'h07);
        tick();
        check("halt_pulse_end", {31'h0, sim_halt}, 32'h0);
        check("halt_code_hold", {24'h0, halt_code}, 32'h07);
        bus.rdy = 1'b0; bus.mem_wr = 1'b1; bus.mem_a = 32'h0003_0004; bus.mem_wdata = 8'h99;
        tick();
        check("halt_rdy0_pulse", {31'h0, sim_halt}, 32'h0);
        check("halt_rdy0_code", {24'h0, halt_code}, 32'h07);
        bus.mem_wr = 1'b0; bus.mem_a = 32'h0;

        // rdy gating: no RAM write, no TX push, no RX pop; TX drain continues
        bus_read(32'h0000_0010, 8'hAB, "gate_pre_read");
        tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'hB1);
        bus_write(32'h0003_0000, 8'hB2);
        tx_ready = 1'b1;
        bus.rdy = 1'b0; bus.mem_wr = 1'b1; bus.mem_a = 32'h0000_0010; bus.mem_wdata = 8'h99;
        tick(); tick(); tick();
        check("gate_rdata_hold", {24'h0, bus.mem_rdata}, 32'hAB);
        check("gate_tx_drained", {31'h0, tx_valid}, 32'h0);
        bus.mem_a = 32'h0003_0000;
        tick();
        check("gate_no_tx_push", {31'h0, tx_valid}, 32'h0);
        bus.mem_wr = 1'b0; bus.mem_a = 32'h0;
        rx_data = 8'h3C; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        bus.mem_a = 32'h0003_0000; tick(); bus.mem_a = 32'h0;
        bus_read(32'h0000_0010, 8'hAB, "gate_ram_unchanged");
        bus_read(32'h0003_0000, 8'h3C, "gate_no_rx_pop");

        // Reset mid-stream
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) bus_write(32'h0003_0000, 8'hC0 + 8'(i));
        rx_data = 8'h4D; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        check("pre_rst_io_full", {31'h0, bus.io_buffer_full}, 32'h1);
        check("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
        check("pre_rst_tx_data", {24'h0, tx_data}, 32'hC0);
        rst = 1'b1;
        bus.rdy = 1'b1; bus.mem_wr = 1'b1; bus.mem_a = 32'h0000_0010; bus.mem_wdata = 8'h55;
        tick();
        rst = 1'b0;
        bus.rdy = 1'b0; bus.mem_wr = 1'b0; bus.mem_a = 32'h0;
        check("post_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("post_rst_io_full", {31'h0, bus.io_buffer_full}, 32'h0);
        check("post_rst_ovf", {31'h0, tx_overflow}, 32'h0);
        check("post_rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("post_rst_halt_code", {24'h0, halt_code}, 32'h0);
        bus_read(32'h0003_0004, 8'h00, "post_rst_status");
        bus_read(32'h0000_0010, 8'hAB, "post_rst_ram_kept");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
